// File: rtl/tick_timer_sched.sv
// Shares a one-per-second tick among NCH countdown channels. Channels are
// loaded through a round-robin arbitrated port and pulse done on expiry.

module tick_timer_chan #(
  parameter int CW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          tick,
  input  logic          load,
  input  logic [CW-1:0] load_val,
  input  logic          cancel,
  output logic          busy,
  output logic          done
);
  typedef enum logic {IDLE, RUN} state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          done_q, done_d;

  // load beats cancel beats tick; a zero load expires immediately
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    if (load) begin
      if (load_val != '0) begin
        state_d = RUN;
        cnt_d   = load_val;
      end else begin
        state_d = IDLE;
        cnt_d   = '0;
        done_d  = 1'b1;
      end
    end else if (state_q == RUN) begin
      if (cancel) begin
        state_d = IDLE;
        cnt_d   = '0;
      end else if (tick) begin
        if (cnt_q == CW'(1)) begin
          state_d = IDLE;
          cnt_d   = '0;
          done_d  = 1'b1;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
    end
  end

  assign busy = (state_q == RUN);
  assign done = done_q;
endmodule

module tick_timer_sched #(
  parameter int NCH = 4,
  parameter int CW  = 8,
  localparam int PW = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              tick,
  input  logic [NCH-1:0]    req,
  input  logic [NCH*CW-1:0] req_val,
  input  logic [NCH-1:0]    cancel,
  output logic [NCH-1:0]    gnt,
  output logic [NCH-1:0]    busy,
  output logic [NCH-1:0]    done,
  output logic [PW-1:0]     rr_ptr
);
  logic [NCH-1:0] elig, gnt_d, gnt_q;
  logic [PW-1:0]  rr_ptr_d, rr_ptr_q;
  logic [PW:0]    sum, nxt;
  logic [PW-1:0]  idx;

  // the live grant masks its requester until it has dropped req
  always_comb begin
    elig     = req & ~gnt_q;
    gnt_d    = '0;
    rr_ptr_d = rr_ptr_q;
    sum      = '0;
    nxt      = '0;
    idx      = '0;
    for (int k = 0; k < NCH; k++) begin
      sum = {1'b0, rr_ptr_q} + (PW+1)'(k);
      if (sum >= (PW+1)'(NCH)) sum = sum - (PW+1)'(NCH);
      idx = sum[PW-1:0];
      if (gnt_d == '0 && elig[idx]) begin
        gnt_d[idx] = 1'b1;
        nxt = {1'b0, idx} + (PW+1)'(1);
        if (nxt == (PW+1)'(NCH)) nxt = '0;
        rr_ptr_d = nxt[PW-1:0];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      gnt_q    <= '0;
      rr_ptr_q <= '0;
    end else begin
      gnt_q    <= gnt_d;
      rr_ptr_q <= rr_ptr_d;
    end
  end

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    tick_timer_chan #(.CW(CW)) u_ch (
      .clk      (clk),
      .rst_n    (rst_n),
      .tick     (tick),
      .load     (gnt_d[i]),
      .load_val (req_val[i*CW +: CW]),
      .cancel   (cancel[i]),
      .busy     (busy[i]),
      .done     (done[i])
    );
  end

  assign gnt    = gnt_q;
  assign rr_ptr = rr_ptr_q;
endmodule

// File: tb/tb_tick_timer_sched.sv
// Directed bench for tick_timer_sched with a per-cycle reference model.

module tb_tick_timer_sched;
  localparam int NCH = 4;
  localparam int CW  = 8;
  localparam int PW  = 2;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              tick;
  logic [NCH-1:0]    req;
  logic [NCH*CW-1:0] req_val;
  logic [NCH-1:0]    cancel;
  logic [NCH-1:0]    gnt, busy, done;
  logic [PW-1:0]     rr_ptr;

  int n_cmp = 0;
  int n_bad = 0;

  tick_timer_sched #(.NCH(NCH), .CW(CW)) dut (
    .clk(clk), .rst_n(rst_n), .tick(tick), .req(req), .req_val(req_val),
    .cancel(cancel), .gnt(gnt), .busy(busy), .done(done), .rr_ptr(rr_ptr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  // Reference model: remaining seconds per channel, 0 meaning idle.
  int             rem [NCH];
  int             m_ptr, win, c;
  logic [NCH-1:0] m_gnt, m_done, m_busy, elig, ng, nd;
  logic [CW-1:0]  v;

  always @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NCH; i++) rem[i] = 0;
      m_gnt = '0; m_done = '0; m_ptr = 0;
    end else begin
      elig = req & ~m_gnt;
      win  = -1;
      for (int k = 0; k < NCH; k++) begin
        c = (m_ptr + k) % NCH;
        if (win < 0 && elig[c]) win = c;
      end
      ng = '0; nd = '0;
      for (int i = 0; i < NCH; i++) begin
        v = req_val[i*CW +: CW];
        if (i == win) begin
          ng[i]  = 1'b1;
          rem[i] = int'(v);
          if (v == '0) nd[i] = 1'b1;
        end else if (rem[i] > 0 && cancel[i]) begin
          rem[i] = 0;
        end else if (rem[i] > 0 && tick) begin
          rem[i] = rem[i] - 1;
          if (rem[i] == 0) nd[i] = 1'b1;
        end
      end
      if (win >= 0) m_ptr = (win + 1) % NCH;
      m_gnt = ng; m_done = nd;
    end
    for (int i = 0; i < NCH; i++) m_busy[i] = (rem[i] > 0);
    #1;
    chk("model_gnt", 32'(gnt), 32'(m_gnt));
    chk("model_busy", 32'(busy), 32'(m_busy));
    chk("model_done", 32'(done), 32'(m_done));
    chk("model_rr_ptr", 32'(rr_ptr), 32'(m_ptr));
  end

  // Advance n cycles; pulses clear and requesters drop req once granted.
  task automatic step(input int n);
    repeat (n) begin
      @(negedge clk);
      tick   = 1'b0;
      cancel = '0;
      req    = req & ~gnt;
    end
  endtask

  task automatic pulse_tick();
    tick = 1'b1;
    step(1);
  endtask

  task automatic set_val(input int ch, input int val);
    req_val[ch*CW +: CW] = CW'(val);
  endtask

  initial begin
    rst_n = 1'b0; tick = 1'b0; req = '0; req_val = '0; cancel = '0;
    step(2);
    chk("reset_gnt", 32'(gnt), 0);
    chk("reset_busy", 32'(busy), 0);
    chk("reset_done", 32'(done), 0);
    chk("reset_rr_ptr", 32'(rr_ptr), 0);
    rst_n = 1'b1;

    // single load of 3, ticks 10 cycles apart
    req = 4'b0001; set_val(0, 3);
    step(1);
    chk("load_gnt", 32'(gnt), 32'h1);
    chk("load_busy", 32'(busy), 32'h1);
    for (int t = 0; t < 3; t++) begin
      step(9);
      pulse_tick();
    end
    chk("expire_done", 32'(done), 32'h1);
    step(1);
    chk("expire_done_width", 32'(done), 0);
    chk("expire_busy", 32'(busy), 0);

    // advance pointer to 2, then round robin over all four
    req = 4'b0010; set_val(1, 5);
    step(1);
    chk("pre_rr_ptr", 32'(rr_ptr), 2);
    for (int i = 0; i < NCH; i++) set_val(i, 5);
    req = 4'b1111;
    step(1); chk("rr_gnt0", 32'(gnt), 32'b0100);
    step(1); chk("rr_gnt1", 32'(gnt), 32'b1000);
    step(1); chk("rr_gnt2", 32'(gnt), 32'b0001);
    step(1); chk("rr_gnt3", 32'(gnt), 32'b0010);
    step(1); chk("rr_idle_gnt", 32'(gnt), 0);
    chk("rr_final_ptr", 32'(rr_ptr), 2);
    cancel = 4'b1111;
    step(1);
    chk("cancel_all_busy", 32'(busy), 0);

    // cancel wins over an expiring tick
    req = 4'b0010; set_val(1, 1);
    step(2);
    tick = 1'b1; cancel = 4'b0010;
    step(1);
    chk("cancel_tick_busy", 32'(busy), 0);
    chk("cancel_tick_done", 32'(done), 0);
    step(1);
    chk("cancel_tick_done2", 32'(done), 0);

    // reload on an expiring tick restarts the count
    req = 4'b0100; set_val(2, 1);
    step(2);
    req = 4'b0100; set_val(2, 4); tick = 1'b1;
    step(1);
    chk("reload_gnt", 32'(gnt), 32'b0100);
    chk("reload_done", 32'(done), 0);
    chk("reload_busy", 32'(busy), 32'b0100);
    for (int t = 0; t < 3; t++) begin
      step(2);
      pulse_tick();
      chk("reload_no_early_done", 32'(done), 0);
    end
    step(2);
    pulse_tick();
    chk("reload_expire", 32'(done), 32'b0100);

    // zero load expires with the grant
    step(1);
    req = 4'b1000; set_val(3, 0);
    step(1);
    chk("zero_gnt", 32'(gnt), 32'b1000);
    chk("zero_done", 32'(done), 32'b1000);
    chk("zero_busy", 32'(busy), 0);
    step(1);
    chk("zero_done_width", 32'(done), 0);

    // two channels loaded on different cycles expire together
    req = 4'b0001; set_val(0, 2);
    step(2);
    req = 4'b0100; set_val(2, 2);
    step(2);
    pulse_tick();
    chk("concurrent_first", 32'(done), 0);
    step(3);
    pulse_tick();
    chk("concurrent_done", 32'(done), 32'b0101);
    step(1);
    chk("concurrent_width", 32'(done), 0);
    chk("concurrent_busy", 32'(busy), 0);

    // reset mid-count discards the count, ignores tick and req
    req = 4'b0001; set_val(0, 7);
    step(2);
    chk("pre_reset_busy", 32'(busy), 32'b0001);
    rst_n = 1'b0; tick = 1'b1; req = 4'b0010;
    step(1);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_gnt", 32'(gnt), 0);
    chk("rst_ptr", 32'(rr_ptr), 0);
    rst_n = 1'b1; req = '0;
    for (int t = 0; t < 8; t++) begin
      step(1);
      pulse_tick();
      chk("post_rst_done", 32'(done), 0);
    end
    step(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
